rom_dl_sequencer: RTL
=====================

Name: rom_dl_sequencer

Overview:
- Sequences ROM-download byte writes from the host ioctl interface into their final homes: SDRAM port1 (main CPU and sound CPU ROM), SDRAM port2 (sprite ROM merged to 32-bit words), or the on-chip GFX1 RAM.
- Owns the toggle req/ack handshake with the SDRAM controller and returns ioctl_ack to the host.
- Generates rom_loaded and the core reset.
- Sits between the ioctl source and the sdram/mcr3mono instances in the MCR3 mono top level.

Parameters:
SG, 1, 1 = Sounds Good layout (sprites 10000-4FFFF, GFX1 50000-57FFF, sound 58000-77FFF); 0 = Turbo Cheap Squeak layout (sprites 10000-2FFFF, GFX1 30000-37FFF, sound 38000-3FFFF)
RST_HOLD, 16'hFFFF, reload value of the post-load reset delay counter

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ioctl_downl  in  1  download active
ioctl_wr  in  1  byte write strobe (level; rising edge = new byte)
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_ack  out  1  one-cycle pulse: byte committed
port1_req  out  1  toggle request, SDRAM port1
port1_ack  in  1  toggle acknowledge, port1
port1_a  out  24  port1 byte address
port2_req  out  1  toggle request, port2
port2_ack  in  1  toggle acknowledge, port2
port2_a  out  24  port2 byte address
port_ds  out  2  byte strobes {a[0],~a[0]} of the active port address
port_d  out  16  {byte,byte}
port_we  out  1  = ioctl_downl
gfx1_wr  out  1  one-cycle write pulse to GFX1 RAM
gfx1_addr  out  15  ioctl_addr minus GFX1 base
gfx1_data  out  8  byte
status_reset  in  1  OSD reset
button_reset  in  1  board reset button
rom_loaded  out  1  a complete download has been seen
core_reset  out  1  registered core reset
dl_overrun  out  1  sticky: write edge dropped while busy

Behaviour:
- Reset (reset_n low, async): all outputs 0 except core_reset=1. FSM=IDLE. Counter=RST_HOLD.
- Edge detect: ioctl_wr is registered. A new byte is ioctl_downl & ioctl_wr & ~wr_q.
- IDLE, on new byte: latch addr/data and classify.
  - addr<10000: MAIN.
  - addr<GFX1 base: SPR.
  - addr<sound base: GFX1.
  - addr<sound end: SND.
  - Otherwise: DROP.
- Address mapping:
  - MAIN: port1_a=addr.
  - SND: s=addr-base; SG=1: port1_a=base+{s[17],s[15:0],s[16]}; SG=0: port1_a=addr.
  - SPR: s=addr-10000; SG=1: port2_a={s[23:18],s[15:0],s[17:16]}; SG=0: {s[23:17],s[14:0],s[16:15]}.
- Transitions:
  - MAIN/SND: toggle port1_req -> WAIT1.
  - SPR: toggle port2_req -> WAIT2.
  - GFX1: gfx1_wr=1 for one cycle -> DONE.
  - DROP -> DONE.
- WAIT1/WAIT2 -> DONE when the port's req==ack. No timeout.
- DONE: ioctl_ack=1 for exactly one cycle -> IDLE.
- Latency: GFX1/DROP ack 2 cycles after the edge is registered. SDRAM ack 1 cycle after req==ack.
- port1_a, port2_a, port_ds and port_d hold stable from request until DONE.
- A new byte outside IDLE is ignored and sets dl_overrun (cleared only by reset_n).
- ioctl_downl falling mid-transfer: the outstanding handshake still completes, so req/ack never desynchronise.
- Simultaneous ioctl_wr edge and downl fall: downl gates, so the byte is ignored.
- rom_loaded: set on the downl 1->0 edge (registered). Cleared by reset_n or button_reset; button_reset wins on the same cycle.
- Counter (16 bit): loads RST_HOLD while status_reset|button_reset|~rom_loaded. Otherwise decrements and saturates at 0.
- core_reset (registered) = status_reset|button_reset|ioctl_downl|~rom_loaded|(counter==1).

Decomposition:
- Package mcr3_dl_pkg holds:
  - region enum {MAIN,SPR,GFX1,SND,DROP};
  - FSM enum {IDLE,ISSUE,WAIT1,WAIT2,DONE};
  - layout base/end constants for SG=0/1.
- One sub-module, dl_reset_gen: rom_loaded, counter and core_reset.

Test Plan:
- SG=1, write 0x5A at 0x00001 with port1_ack echoing req after 3 cycles -> port1_a=0x000001, port_ds=2'b10, port_d=0x5A5A, single ioctl_ack after ack; port2_req unchanged.
- SG=1, write at 0x10005 -> port2_a = 0x000014 ({6'b0,16'h0005,2'b00}); SG=0 write at 0x18003 -> port2_a = 0x00000D.
- SG=1, write at 0x59000 -> s=0x1000, port1_a=0x58000+{0,0x1000,0}=0x5A000; write at 0x52010 -> gfx1_wr pulse, gfx1_addr=0x2010, no req toggle, ack 2 cycles later.
- Second rising ioctl_wr while in WAIT1 (ack withheld) -> dl_overrun=1, no extra toggle; ioctl_downl dropped before ack -> ack still issued after port1_ack matches.
- Download ends -> rom_loaded=1, core_reset held, then one core_reset pulse at counter==1 (RST_HOLD=4 on the bench), then 0; button_reset -> rom_loaded=0, core_reset=1.
- reset_n asserted mid-WAIT2 -> immediate core_reset=1, req outputs 0, FSM IDLE, ioctl_ack never pulses.

Source files
------------

// File: rtl/mcr3_dl_pkg.sv
// Shared types and address-layout constants for the MCR3 mono ROM download
// sequencer.
//   region_e : where a downloaded byte lands
//   state_e  : sequencer FSM states
//   gfx1_base/snd_base/snd_end : layout boundaries for the two sound-board
//   variants (SG=1 Sounds Good, SG=0 Turbo Cheap Squeak).
package mcr3_dl_pkg;

  typedef enum logic [2:0] {MAIN, SPR, GFX1, SND, DROP} region_e;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT2, DONE} state_e;

  localparam logic [24:0] SPR_BASE     = 25'h10000;
  localparam logic [24:0] SG1_GFX1     = 25'h50000;
  localparam logic [24:0] SG1_SND      = 25'h58000;
  localparam logic [24:0] SG1_SND_END  = 25'h78000;
  localparam logic [24:0] SG0_GFX1     = 25'h30000;
  localparam logic [24:0] SG0_SND      = 25'h38000;
  localparam logic [24:0] SG0_SND_END  = 25'h40000;

  function automatic logic [24:0] gfx1_base(input bit sg);
    return sg ? SG1_GFX1 : SG0_GFX1;
  endfunction

  function automatic logic [24:0] snd_base(input bit sg);
    return sg ? SG1_SND : SG0_SND;
  endfunction

  function automatic logic [24:0] snd_end(input bit sg);
    return sg ? SG1_SND_END : SG0_SND_END;
  endfunction

endpackage

// File: rtl/dl_reset_gen.sv
// Post-download reset generator.
//   clk_sys, reset_n     : clock, async active-low reset
//   ioctl_downl          : download active
//   status_reset         : OSD reset
//   button_reset         : board reset button
//   rom_loaded           : set when a download finishes (downl 1->0)
//   core_reset           : registered core reset
module dl_reset_gen #(
  parameter logic [15:0] RST_HOLD = 16'hFFFF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ioctl_downl,
  input  logic status_reset,
  input  logic button_reset,
  output logic rom_loaded,
  output logic core_reset
);

  logic        downl_q;
  logic        loaded_q, loaded_d;
  logic        rst_q, rst_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    loaded_d = loaded_q;
    if (downl_q && !ioctl_downl) loaded_d = 1'b1;
    // Button clears even if the download ends on the same cycle.
    if (button_reset) loaded_d = 1'b0;

    if (status_reset || button_reset || !loaded_q) cnt_d = RST_HOLD;
    else if (cnt_q != 16'd0)                       cnt_d = cnt_q - 16'd1;
    else                                           cnt_d = cnt_q;

    // The counter==1 term gives one extra reset pulse once the hold expires.
    rst_d = status_reset | button_reset | ioctl_downl | ~loaded_q
          | (cnt_q == 16'd1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      downl_q  <= 1'b0;
      loaded_q <= 1'b0;
      cnt_q    <= RST_HOLD;
      rst_q    <= 1'b1;
    end else begin
      downl_q  <= ioctl_downl;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      rst_q    <= rst_d;
    end
  end

  assign rom_loaded = loaded_q;
  assign core_reset = rst_q;

endmodule

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: routes host ioctl byte writes to SDRAM port1
// (main/sound CPU ROM), SDRAM port2 (sprite ROM, swizzled for 32-bit words)
// or the GFX1 RAM, runs the toggle req/ack handshake, and acks the host.
//   ioctl_*        : host download interface (ioctl_ack = byte committed)
//   port1_*/port2_*: SDRAM toggle-handshake ports, port_ds/port_d/port_we shared
//   gfx1_*         : GFX1 RAM write pulse, offset address, data
//   status_reset, button_reset, rom_loaded, core_reset : reset generation
//   dl_overrun     : sticky, a write edge arrived while busy
module rom_dl_sequencer
  import mcr3_dl_pkg::*;
#(
  parameter bit          SG       = 1'b1,
  parameter logic [15:0] RST_HOLD = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_ack,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [23:0] port1_a,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [23:0] port2_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        port_we,
  output logic        gfx1_wr,
  output logic [14:0] gfx1_addr,
  output logic [7:0]  gfx1_data,
  input  logic        status_reset,
  input  logic        button_reset,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        dl_overrun
);

  localparam logic [24:0] GFX1_BASE = gfx1_base(SG);
  localparam logic [24:0] SND_BASE  = snd_base(SG);
  localparam logic [24:0] SND_END   = snd_end(SG);

  state_e      state_q, state_d;
  region_e     region_q, region_in;
  logic        wr_q, new_byte, take;
  logic        p1_req_q, p1_req_d, p2_req_q, p2_req_d;
  logic        ovr_q, ovr_d;
  logic        ack_c, gwr_c;
  logic [23:0] p1_a_q, p2_a_q;
  logic [1:0]  ds_q;
  logic [7:0]  byte_q;
  logic [14:0] gfx_a_q;

  logic [17:0] s_snd;
  logic [23:0] snd_sw, s_spr, p1_map, spr_map;
  logic [14:0] gfx_off;

  assign new_byte = ioctl_downl & ioctl_wr & ~wr_q;

  // Classify and map the incoming address; only latched when accepted.
  always_comb begin
    if      (ioctl_addr < SPR_BASE)  region_in = MAIN;
    else if (ioctl_addr < GFX1_BASE) region_in = SPR;
    else if (ioctl_addr < SND_BASE)  region_in = GFX1;
    else if (ioctl_addr < SND_END)   region_in = SND;
    else                             region_in = DROP;

    // Sounds Good sound ROM: bit 16 of the offset moves down to bit 0.
    s_snd  = 18'(ioctl_addr - SND_BASE);
    snd_sw = SND_BASE[23:0] + {6'b0, s_snd[17], s_snd[15:0], s_snd[16]};
    p1_map = (SG && region_in == SND) ? snd_sw : ioctl_addr[23:0];

    // Sprite planes interleave into 32-bit words: plane select to low bits.
    s_spr   = 24'(ioctl_addr - SPR_BASE);
    spr_map = SG ? {s_spr[23:18], s_spr[15:0], s_spr[17:16]}
                 : {s_spr[23:17], s_spr[14:0], s_spr[16:15]};

    gfx_off = 15'(ioctl_addr - GFX1_BASE);
  end

  always_comb begin
    state_d  = state_q;
    p1_req_d = p1_req_q;
    p2_req_d = p2_req_q;
    take     = 1'b0;
    ack_c    = 1'b0;
    gwr_c    = 1'b0;
    ovr_d    = ovr_q | (new_byte && state_q != IDLE);
    case (state_q)
      IDLE: if (new_byte) begin
        take    = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: case (region_q)
        MAIN, SND: begin
          p1_req_d = ~p1_req_q;
          state_d  = WAIT1;
        end
        SPR: begin
          p2_req_d = ~p2_req_q;
          state_d  = WAIT2;
        end
        GFX1: begin
          gwr_c   = 1'b1;
          state_d = DONE;
        end
        default: state_d = DONE;
      endcase
      // No timeout: the handshake always completes, even if downl drops.
      WAIT1: if (p1_req_q == port1_ack) state_d = DONE;
      WAIT2: if (p2_req_q == port2_ack) state_d = DONE;
      DONE: begin
        ack_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q     <= 1'b0;
      p1_req_q <= 1'b0;
      p2_req_q <= 1'b0;
      ovr_q    <= 1'b0;
      region_q <= MAIN;
      byte_q   <= '0;
      p1_a_q   <= '0;
      p2_a_q   <= '0;
      ds_q     <= '0;
      gfx_a_q  <= '0;
    end else begin
      wr_q     <= ioctl_wr;
      p1_req_q <= p1_req_d;
      p2_req_q <= p2_req_d;
      ovr_q    <= ovr_d;
      if (take) begin
        region_q <= region_in;
        byte_q   <= ioctl_dout;
        case (region_in)
          MAIN, SND: begin
            p1_a_q <= p1_map;
            ds_q   <= {p1_map[0], ~p1_map[0]};
          end
          SPR: begin
            p2_a_q <= spr_map;
            ds_q   <= {spr_map[0], ~spr_map[0]};
          end
          GFX1:    gfx_a_q <= gfx_off;
          default: ;
        endcase
      end
    end
  end

  assign ioctl_ack  = ack_c;
  assign port1_req  = p1_req_q;
  assign port2_req  = p2_req_q;
  assign port1_a    = p1_a_q;
  assign port2_a    = p2_a_q;
  assign port_ds    = ds_q;
  assign port_d     = {byte_q, byte_q};
  assign port_we    = ioctl_downl;
  assign gfx1_wr    = gwr_c;
  assign gfx1_addr  = gfx_a_q;
  assign gfx1_data  = byte_q;
  assign dl_overrun = ovr_q;

  dl_reset_gen #(.RST_HOLD(RST_HOLD)) u_rst (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_downl  (ioctl_downl),
    .status_reset (status_reset),
    .button_reset (button_reset),
    .rom_loaded   (rom_loaded),
    .core_reset   (core_reset)
  );

endmodule
